// File: rtl/core_ctrl_pkg.sv
// Shared pipeline-control definitions: controller state encoding, control word, bubble encoding.
// Imported by the hazard controller and by the pipeline registers that load bubbles.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // A flushed pipeline register loads this instruction with its writeback disabled.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic        NOP_WB   = 1'b0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ie_en;
    logic ie_imem_en;
    logic imem_wb_en;
    logic if_id_flush;
    logic id_ie_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctl_t CTL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctl_t CTL_IMISS  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and per-stage enable/flush outputs of the pipeline controller.
// master = controller side, slave = pipeline/hazard-detect side.
interface pipe_ctrl_if #(
  parameter int PERF_W = 32
) ();
  logic              br_stall;
  logic              lu_stall;
  logic              redirect;
  logic              imem_ready;
  logic              dmem_req;
  logic              dmem_ready;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ie_en;
  logic              ie_imem_en;
  logic              imem_wb_en;
  logic              if_id_flush;
  logic              id_ie_flush;
  logic              bus_err;
  logic [PERF_W-1:0] stall_cyc;
  logic [PERF_W-1:0] flush_cnt;

  modport master (
    input  br_stall, lu_stall, redirect, imem_ready, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ie_en, ie_imem_en, imem_wb_en,
    output if_id_flush, id_ie_flush, bus_err, stall_cyc, flush_cnt
  );

  modport slave (
    output br_stall, lu_stall, redirect, imem_ready, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ie_en, ie_imem_en, imem_wb_en,
    input  if_id_flush, id_ie_flush, bus_err, stall_cyc, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Data-memory wait watchdog: counts consecutive wait cycles, saturating at DMEM_TIMEOUT.
// o_expired flags the last allowed wait cycle; i_clr has priority over i_inc.
module pipe_ctrl_wdog #(
  parameter int DMEM_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  localparam logic [TO_W-1:0] LP_LAST = TO_W'(DMEM_TIMEOUT - 1);
  localparam logic [TO_W-1:0] LP_MAX  = TO_W'(DMEM_TIMEOUT);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LP_LAST);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: zero-latency per-stage enables/flushes plus dmem watchdog.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 64,
  parameter int TO_W         = 7,
  parameter int PERF_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.master   bus
);
  state_t r_state;
  state_t w_next;
  ctl_t   w_ctl;
  logic   w_mem_wait;
  logic   w_wd_clr;
  logic   w_wd_inc;
  logic   w_wd_expired;

  assign w_mem_wait = bus.dmem_req & ~bus.dmem_ready;

  pipe_ctrl_wdog #(
    .DMEM_TIMEOUT (DMEM_TIMEOUT),
    .TO_W         (TO_W)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wd_clr),
    .i_inc     (w_wd_inc),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ctl    = CTL_RUN;
    w_wd_clr = 1'b1;
    w_wd_inc = 1'b0;
    unique case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_wait) begin
          // Full freeze: a redirect here stays asserted in the frozen IE and is taken on release.
          w_ctl    = CTL_FREEZE;
          w_wd_clr = 1'b0;
          w_wd_inc = 1'b1;
          w_next   = ((r_state == MEM_WAIT) && w_wd_expired) ? ERR : MEM_WAIT;
        end else begin
          w_next = RUN;
          if (bus.redirect) begin
            w_ctl = CTL_REDIR;
          end else if (bus.br_stall || bus.lu_stall) begin
            w_ctl = CTL_STALL;
          end else if (!bus.imem_ready) begin
            w_ctl = CTL_IMISS;
          end
        end
      end
      ERR: begin
        w_ctl    = CTL_FREEZE;
        w_wd_clr = 1'b0;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  assign bus.pc_en       = w_ctl.pc_en;
  assign bus.if_id_en    = w_ctl.if_id_en;
  assign bus.id_ie_en    = w_ctl.id_ie_en;
  assign bus.ie_imem_en  = w_ctl.ie_imem_en;
  assign bus.imem_wb_en  = w_ctl.imem_wb_en;
  assign bus.if_id_flush = w_ctl.if_id_flush;
  assign bus.id_ie_flush = w_ctl.id_ie_flush;
  assign bus.bus_err     = (r_state == ERR);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cyc;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctl.pc_en && (r_state != ERR)) begin
        r_stall_cyc <= r_stall_cyc + 1'b1;
      end
      if (w_ctl.if_id_flush || w_ctl.id_ie_flush) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_cyc = r_stall_cyc;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cyc = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule
